// File: rtl/pipe_ctrl.sv
// Pipeline controller: FSM (IDLE/RUN/DRAIN/HALTED), fetch PC, stage enables/valids, hazard handling.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int unsigned      PC_W     = 16,
  parameter int unsigned      DEPTH    = 5,
  parameter int unsigned      REG_AW   = 4,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mem_ready,
  input  logic              halt_dec,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_load,
  output logic [PC_W-1:0]   pc,
  output logic [DEPTH-1:0]  stage_en,
  output logic [DEPTH-1:0]  stage_valid,
  output logic [1:0]        state,
  output logic              halted,
  output logic [15:0]       cyc_cnt,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [DEPTH-1:0] valid_q, valid_d, stage_en_c, shifted;
  logic             sync1_q, sync2_q;
  logic             busy, flush, load_use, halt_go;

  // Reset assertion is immediate; release takes effect only once sync2_q is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= 1'b1;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    busy     = (state_q == RUN) || (state_q == DRAIN);
    flush    = busy & br_taken & valid_q[2];
    load_use = busy & ex_load & valid_q[2] & valid_q[1] &
               ((id_use1 & (id_rs1 == ex_rd)) | (id_use2 & (id_rs2 == ex_rd)));
    halt_go  = (state_q == RUN) & halt_dec & valid_q[1];
    shifted  = {valid_q[DEPTH-2:0], 1'b0};
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    stage_en_c = '0;
    if (sync2_q && mem_ready) begin
      unique case (state_q)
        IDLE, HALTED: begin
          if (start) begin
            state_d = RUN;
            pc_d    = RESET_PC;
            valid_d = '0;
          end
        end
        default: begin
          stage_en_c = '1;
          if (flush) begin
            // Older stages keep shifting; in DRAIN the redirect is recorded but nothing is fetched.
            pc_d         = br_target;
            valid_d      = shifted;
            valid_d[1:0] = 2'b00;
          end else if (load_use) begin
            stage_en_c[1:0] = 2'b00;
            valid_d         = shifted;
            valid_d[2]      = 1'b0;
            valid_d[1:0]    = valid_q[1:0];
          end else if (state_q == DRAIN) begin
            valid_d = shifted;
            if (valid_q == '0) state_d = HALTED;
          end else if (halt_go) begin
            valid_d = shifted;
            state_d = DRAIN;
          end else begin
            pc_d    = pc_q + PC_W'(1);
            valid_d = {valid_q[DEPTH-2:0], 1'b1};
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign pc          = pc_q;
  assign stage_en    = stage_en_c;
  assign stage_valid = valid_q;
  assign state       = state_q;
  assign halted      = (state_q == HALTED);

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] cyc_q, cyc_d, stall_q, stall_d, flush_q, flush_d;
  logic        start_clr, ev_stall, ev_flush;

  always_comb begin
    start_clr = sync2_q & mem_ready & start & ((state_q == IDLE) || (state_q == HALTED));
    ev_flush  = sync2_q & mem_ready & flush;
    ev_stall  = sync2_q & busy & (!mem_ready | (load_use & !flush));
    cyc_d     = cyc_q;
    stall_d   = stall_q;
    flush_d   = flush_q;
    if (start_clr) begin
      cyc_d   = '0;
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (sync2_q && busy && cyc_q != '1) cyc_d   = cyc_q + 16'd1;
      if (ev_stall && stall_q != '1)      stall_d = stall_q + 16'd1;
      if (ev_flush && flush_q != '1)      flush_d = flush_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign cyc_cnt   = cyc_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign cyc_cnt   = '0;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
